// File: rtl/hazard_stall_controller_pkg.sv
// Shared definitions for the hazard stall controller: RV32I opcodes, FSM states, register ids.
package hazard_stall_controller_pkg;

   localparam logic [6:0] LOAD           = 7'b0000011;
   localparam logic [6:0] STORE          = 7'b0100011;
   localparam logic [6:0] BRANCH         = 7'b1100011;
   localparam logic [6:0] ARITHMETIC     = 7'b0110011;
   localparam logic [6:0] ARITHMETIC_IMM = 7'b0010011;
   localparam logic [6:0] JAL            = 7'b1101111;
   localparam logic [6:0] JALR           = 7'b1100111;
   localparam logic [6:0] LUI            = 7'b0110111;
   localparam logic [6:0] AUIPC          = 7'b0010111;
   localparam logic [6:0] ECALL          = 7'b1110011;

   localparam logic [4:0] REG_X17 = 5'd17;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      STALL  = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } state_t;

endpackage

// File: rtl/hazard_stall_controller_src_reg_usage.sv
// Decodes which source register fields of an RV32I instruction are actually read.
module src_reg_usage
   import hazard_stall_controller_pkg::*;
(
   input  logic [31:0] i_inst,
   output logic        o_uses_rs1,
   output logic        o_uses_rs2
);

   logic [6:0] w_opcode;
   logic       w_unused_fields;

   assign w_opcode        = i_inst[6:0];
   assign w_unused_fields = ^i_inst[31:7];

   // U-type and JAL carry immediate bits where rs1 would sit.
   assign o_uses_rs1 = !((w_opcode == LUI) || (w_opcode == AUIPC) || (w_opcode == JAL));
   assign o_uses_rs2 = (w_opcode == ARITHMETIC) || (w_opcode == STORE) || (w_opcode == BRANCH);

endmodule

// File: rtl/hazard_stall_controller.sv
// Load-use / ecall stall generator and halt sequencer for the 5-stage RV32I pipeline.
// Optional saturating stall counter enabled by defining HAZARD_STALL_COUNT_EN.
module hazard_stall_controller #(
   parameter int unsigned HALT_DRAIN = 3,
   parameter logic [31:0] HALT_CODE  = 32'd10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] if_id_inst,
   input  logic [31:0] id_ex_inst,
   input  logic        id_ex_mem_read,
   input  logic        id_ex_reg_write,
   input  logic [31:0] ex_mem_inst,
   input  logic        ex_mem_mem_read,
   input  logic        is_ecall,
   input  logic [31:0] x17_value,
   input  logic        ex_flush,
   output logic        pc_write,
   output logic        if_id_write,
   output logic        id_ex_bubble,
   output logic        is_halted,
   output logic [31:0] stall_cycles
);
   import hazard_stall_controller_pkg::*;

   localparam logic [2:0] DRAIN_LOAD = 3'(HALT_DRAIN - 1);

   logic       w_uses_rs1;
   logic       w_uses_rs2;
   logic [4:0] w_rs1;
   logic [4:0] w_rs2;
   logic [4:0] w_id_ex_rd;
   logic [4:0] w_ex_mem_rd;
   logic       w_lu_hazard;
   logic       w_ecall_hazard;
   logic       w_hazard;
   logic       w_halt_req;
   logic       w_unused_bits;
   state_t     r_state;
   state_t     w_next_state;
   logic [2:0] r_drain_cnt;

   src_reg_usage u_src_reg_usage (
      .i_inst     (if_id_inst),
      .o_uses_rs1 (w_uses_rs1),
      .o_uses_rs2 (w_uses_rs2)
   );

   assign w_rs1         = if_id_inst[19:15];
   assign w_rs2         = if_id_inst[24:20];
   assign w_id_ex_rd    = id_ex_inst[11:7];
   assign w_ex_mem_rd   = ex_mem_inst[11:7];
   assign w_unused_bits = ^{id_ex_inst[31:12], id_ex_inst[6:0], ex_mem_inst[31:12], ex_mem_inst[6:0]};

   assign w_lu_hazard = id_ex_mem_read && (w_id_ex_rd != 5'd0) &&
                        ((w_uses_rs1 && (w_rs1 == w_id_ex_rd)) ||
                         (w_uses_rs2 && (w_rs2 == w_id_ex_rd)));

   assign w_ecall_hazard = is_ecall &&
                           ((id_ex_reg_write && (w_id_ex_rd == REG_X17)) ||
                            (ex_mem_mem_read && (w_ex_mem_rd == REG_X17)));

   // A mispredict squashes the ID instruction, so its hazards and halt request are void.
   assign w_hazard   = (w_lu_hazard || w_ecall_hazard) && !ex_flush;
   assign w_halt_req = is_ecall && (x17_value == HALT_CODE) && !ex_flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= RUN;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_drain_cnt <= 3'd0;
      end else if ((w_next_state == DRAIN) && (r_state != DRAIN)) begin
         r_drain_cnt <= DRAIN_LOAD;
      end else if ((r_state == DRAIN) && (r_drain_cnt != 3'd0)) begin
         r_drain_cnt <= r_drain_cnt - 3'd1;
      end
   end

   always_comb begin
      w_next_state = r_state;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_bubble = 1'b0;
      case (r_state)
         RUN, STALL: begin
            pc_write     = !w_hazard;
            if_id_write  = !w_hazard;
            id_ex_bubble = w_hazard || ex_flush;
            if (w_hazard) begin
               w_next_state = STALL;
            end else if (w_halt_req) begin
               w_next_state = DRAIN;
            end else begin
               w_next_state = RUN;
            end
         end
         DRAIN: begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (r_drain_cnt == 3'd0) begin
               w_next_state = HALTED;
            end
         end
         HALTED: begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
         end
      endcase
   end

   assign is_halted = (r_state == HALTED);

`ifdef HAZARD_STALL_COUNT_EN
   logic [31:0] r_stall_cycles;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stall_cycles <= 32'd0;
      end else if (((r_state == RUN) || (r_state == STALL)) && w_hazard &&
                   (r_stall_cycles != 32'hFFFF_FFFF)) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
`else
   assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed scoreboard bench for hazard_stall_controller: driver queues expectations, monitor checks each negedge.
module tb_hazard_stall_controller;
   import hazard_stall_controller_pkg::*;

   localparam int unsigned HALT_DRAIN = 3;
   localparam logic [31:0] HALT_CODE  = 32'd10;
   localparam logic [31:0] NOP        = 32'h0000_0013;
   localparam logic [31:0] ECALL_INST = 32'h0000_0073;

   typedef struct packed {
      logic        pcWrite;
      logic        ifIdWrite;
      logic        bubble;
      logic        halted;
      logic [31:0] stallCycles;
   } expect_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] ifIdInst = NOP;
   logic [31:0] idExInst = NOP;
   logic        idExMemRead = 1'b0;
   logic        idExRegWrite = 1'b0;
   logic [31:0] exMemInst = NOP;
   logic        exMemMemRead = 1'b0;
   logic        isEcall = 1'b0;
   logic [31:0] x17Value = 32'd0;
   logic        exFlush = 1'b0;
   logic        pcWrite;
   logic        ifIdWrite;
   logic        idExBubble;
   logic        isHalted;
   logic [31:0] stallCycles;

   expect_t     expQ[$];
   string       nameQ[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] expStall = 32'd0;

   logic [31:0] lwX5, lwX0, lwX17, addX6X5X2, addX6X0X0, addiX6X7, swX5, luiX6, addX5, addiX17, swX17;

   hazard_stall_controller #(
      .HALT_DRAIN (HALT_DRAIN),
      .HALT_CODE  (HALT_CODE)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .if_id_inst      (ifIdInst),
      .id_ex_inst      (idExInst),
      .id_ex_mem_read  (idExMemRead),
      .id_ex_reg_write (idExRegWrite),
      .ex_mem_inst     (exMemInst),
      .ex_mem_mem_read (exMemMemRead),
      .is_ecall        (isEcall),
      .x17_value       (x17Value),
      .ex_flush        (exFlush),
      .pc_write        (pcWrite),
      .if_id_write     (ifIdWrite),
      .id_ex_bubble    (idExBubble),
      .is_halted       (isHalted),
      .stall_cycles    (stallCycles)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mkI(input logic [11:0] imm, input logic [4:0] rs1,
                                       input logic [4:0] rd, input logic [6:0] op);
      return {imm, rs1, 3'b010, rd, op};
   endfunction

   function automatic logic [31:0] mkR(input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [4:0] rd, input logic [6:0] op);
      return {7'd0, rs2, rs1, 3'b000, rd, op};
   endfunction

   task automatic pushExpect(input string name, input logic pw, input logic iw,
                             input logic bub, input logic halt);
      expect_t e;
      e = '{pcWrite: pw, ifIdWrite: iw, bubble: bub, halted: halt, stallCycles: expStall};
      expQ.push_back(e);
      nameQ.push_back(name);
   endtask

   // Drives one cycle of pipeline state after the edge and records what the outputs must be.
   task automatic applyStimulus(input string name,
                                input logic [31:0] ifId, input logic [31:0] idEx,
                                input logic idExMr, input logic idExRw,
                                input logic [31:0] exMem, input logic exMemMr,
                                input logic ecall, input logic [31:0] x17, input logic flush,
                                input logic pw, input logic iw, input logic bub, input logic halt,
                                input logic counted);
      @(posedge clk);
      #1;
      ifIdInst     = ifId;
      idExInst     = idEx;
      idExMemRead  = idExMr;
      idExRegWrite = idExRw;
      exMemInst    = exMem;
      exMemMemRead = exMemMr;
      isEcall      = ecall;
      x17Value     = x17;
      exFlush      = flush;
      pushExpect(name, pw, iw, bub, halt);
`ifdef HAZARD_STALL_COUNT_EN
      if (counted) expStall = expStall + 32'd1;
`else
      if (counted) expStall = 32'd0;
`endif
   endtask

   // Asserts reset between edges and expects the run-state outputs before the next edge.
   task automatic resetMidCycle(input string name);
      @(posedge clk);
      #2;
      reset = 1'b0;
      ifIdInst = NOP; idExInst = NOP; exMemInst = NOP;
      idExMemRead = 1'b0; idExRegWrite = 1'b0; exMemMemRead = 1'b0;
      isEcall = 1'b0; x17Value = 32'd0; exFlush = 1'b0;
      expStall = 32'd0;
      pushExpect(name, 1'b1, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic checkOutput(input string name, input expect_t e);
      expect_t act;
      act = '{pcWrite: pcWrite, ifIdWrite: ifIdWrite, bubble: idExBubble, halted: isHalted,
              stallCycles: stallCycles};
      checks++;
      if (act !== e) begin
         errors++;
         $display("[TB] FAIL %s: got pc=%b ifid=%b bub=%b halt=%b sc=%0d, expected pc=%b ifid=%b bub=%b halt=%b sc=%0d",
                  name, act.pcWrite, act.ifIdWrite, act.bubble, act.halted, act.stallCycles,
                  e.pcWrite, e.ifIdWrite, e.bubble, e.halted, e.stallCycles);
      end
   endtask

   // Monitor: every falling edge, compare whatever expectations the driver has queued.
   initial begin : monitor
      expect_t e;
      string   n;
      forever begin
         @(negedge clk);
         while (expQ.size() > 0) begin
            e = expQ.pop_front();
            n = nameQ.pop_front();
            checkOutput(n, e);
         end
      end
   end

   initial begin : driver
      lwX5      = mkI(12'd0, 5'd1, 5'd5, LOAD);
      lwX0      = mkI(12'd0, 5'd1, 5'd0, LOAD);
      lwX17     = mkI(12'd0, 5'd2, 5'd17, LOAD);
      addX6X5X2 = mkR(5'd2, 5'd5, 5'd6, ARITHMETIC);
      addX6X0X0 = mkR(5'd0, 5'd0, 5'd6, ARITHMETIC);
      addiX6X7  = mkI(12'd5, 5'd7, 5'd6, ARITHMETIC_IMM);
      swX5      = mkR(5'd5, 5'd1, 5'd0, STORE);
      luiX6     = mkI(12'd0, 5'd5, 5'd6, LUI);
      addX5     = mkR(5'd3, 5'd4, 5'd5, ARITHMETIC);
      addiX17   = mkI(12'd93, 5'd0, 5'd17, ARITHMETIC_IMM);
      swX17     = mkR(5'd3, 5'd4, 5'd17, STORE);

      #1;
      reset = 1'b0;
      pushExpect("reset_state", 1'b1, 1'b1, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;

      applyStimulus("lu_stall",     addX6X5X2, lwX5, 1, 1, NOP, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      applyStimulus("lu_release",   addX6X5X2, NOP,  0, 0, lwX5, 1, 0, 0, 0, 1, 1, 0, 0, 0);
      applyStimulus("lu_rs2_store", swX5,      lwX5, 1, 1, NOP, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      applyStimulus("idle",         NOP,       NOP,  0, 0, NOP, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      applyStimulus("x0_load",      addX6X0X0, lwX0, 1, 1, NOP, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      applyStimulus("imm_not_rs2",  addiX6X7,  lwX5, 1, 1, NOP, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      applyStimulus("lui_no_rs1",   luiX6,     lwX5, 1, 1, NOP, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      applyStimulus("alu_no_stall", addX6X5X2, addX5, 0, 1, NOP, 0, 0, 0, 0, 1, 1, 0, 0, 0);

      applyStimulus("ecall_ld_ex",  ECALL_INST, lwX17, 1, 1, NOP, 0, 1, HALT_CODE, 0, 0, 0, 1, 0, 1);
      applyStimulus("ecall_ld_mem", ECALL_INST, NOP, 0, 0, lwX17, 1, 1, HALT_CODE, 0, 0, 0, 1, 0, 1);
      applyStimulus("ecall_ld_go",  ECALL_INST, NOP, 0, 0, NOP, 0, 1, 32'd93, 0, 1, 1, 0, 0, 0);
      applyStimulus("ecall_alu_ex", ECALL_INST, addiX17, 0, 1, NOP, 0, 1, HALT_CODE, 0, 0, 0, 1, 0, 1);
      applyStimulus("ecall_alu_go", ECALL_INST, NOP, 0, 0, addiX17, 0, 1, 32'd64, 0, 1, 1, 0, 0, 0);
      applyStimulus("ecall_no_rw",  ECALL_INST, swX17, 0, 0, NOP, 0, 1, 32'd64, 0, 1, 1, 0, 0, 0);

      applyStimulus("flush_lu",       addX6X5X2, lwX5, 1, 1, NOP, 0, 0, 0, 1, 1, 1, 1, 0, 0);
      applyStimulus("flush_halt",     ECALL_INST, NOP, 0, 0, NOP, 0, 1, HALT_CODE, 1, 1, 1, 1, 0, 0);
      applyStimulus("flush_no_drain", NOP, NOP, 0, 0, NOP, 0, 0, 0, 0, 1, 1, 0, 0, 0);

      applyStimulus("halt_accept", ECALL_INST, NOP, 0, 0, NOP, 0, 1, HALT_CODE, 0, 1, 1, 0, 0, 0);
      for (int i = 0; i < int'(HALT_DRAIN); i++) begin
         applyStimulus($sformatf("drain_%0d", i), addX6X5X2, lwX5, 1, 1, NOP, 0, 0, 0, i[0],
                       0, 0, 1, 0, 0);
      end
      for (int i = 0; i < 20; i++) begin
         applyStimulus($sformatf("halted_%0d", i), (i[0] ? ECALL_INST : addX6X5X2), lwX5, 1, 1,
                       NOP, 0, i[0], HALT_CODE, i[1], 0, 0, 1, 1, 0);
      end

      resetMidCycle("reset_from_halted");
      applyStimulus("after_reset", NOP, NOP, 0, 0, NOP, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus($sformatf("pre_reset_stall_%0d", i), addX6X5X2, lwX5, 1, 1, NOP, 0, 0, 0, 0,
                       0, 0, 1, 0, 1);
         applyStimulus($sformatf("pre_reset_go_%0d", i), addX6X5X2, NOP, 0, 0, lwX5, 1, 0, 0, 0,
                       1, 1, 0, 0, 0);
      end
      applyStimulus("halt_accept2", ECALL_INST, NOP, 0, 0, NOP, 0, 1, HALT_CODE, 0, 1, 1, 0, 0, 0);
      applyStimulus("drain_mid", NOP, NOP, 0, 0, NOP, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      resetMidCycle("reset_mid_drain");
      applyStimulus("post_reset", NOP, NOP, 0, 0, NOP, 0, 0, 0, 0, 1, 1, 0, 0, 0);
      applyStimulus("post_reset_stall", addX6X5X2, lwX5, 1, 1, NOP, 0, 0, 0, 0, 0, 0, 1, 0, 1);
      applyStimulus("post_reset_go", NOP, NOP, 0, 0, NOP, 0, 0, 0, 0, 1, 1, 0, 0, 0);

      repeat (2) @(posedge clk);
      for (int i = 0; (i < 10) && (expQ.size() > 0); i++) begin
         @(posedge clk);
      end
      if (expQ.size() > 0) begin
         errors++;
         $display("[TB] FAIL drain_queue: got %0d pending expectations, expected 0", expQ.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
